param_register_file: RTL and testbench

- Parametrised successor to the 4-entry 8-bit register file; it serves the datapath register operands.
- Configurable data width, register count and read-port count, with one write port.
- Reads are registered: data arrives one cycle after the request, with a valid strobe.
- A per-register pending scoreboard lets multi-cycle producers reserve a destination, so consumers can detect read-after-write hazards.

---
 rtl/rf_pkg.sv | 10 +
 rtl/param_register_file_read_port.sv | 77 +++++++
 rtl/param_register_file.sv | 104 ++++++++++
 tb/tb_param_register_file.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and address type for the parametrised register file.
package rf_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_DEPTH  = 4;
  localparam int RF_N_RD   = 2;

  typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;

endpackage

// File: rtl/param_register_file_read_port.sv
// One registered read port: selects a register and its pending bit, applies
// zero-register masking and the optional same-cycle write bypass.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rd_en,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  input  logic [DEPTH*DATA_W-1:0] i_regs_flat,
  input  logic [DEPTH-1:0]        i_pend_vec,
  input  logic                    i_byp_wr_en,
  input  logic [ADDR_W-1:0]       i_byp_wr_addr,
  input  logic [DATA_W-1:0]       i_byp_wr_data,
  input  logic                    i_byp_rsv_en,
  input  logic [ADDR_W-1:0]       i_byp_rsv_addr,
  output logic [DATA_W-1:0]       o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_pend
);

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic              w_zero_hit;
  logic              w_byp_hit;
  logic [DATA_W-1:0] w_data;
  logic              w_pend;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_pend;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign w_regs[gi] = i_regs_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The bypass reports post-write state: cleared unless a same-address reserve lands too.
  always_comb begin
    w_zero_hit = (ZERO_REG != 0) && (i_rd_addr == '0);
    w_byp_hit  = i_byp_wr_en && (i_byp_wr_addr == i_rd_addr);
    w_data     = w_regs[i_rd_addr];
    w_pend     = i_pend_vec[i_rd_addr];
    if (w_zero_hit) begin
      w_data = '0;
      w_pend = 1'b0;
    end else if (w_byp_hit) begin
      w_data = i_byp_wr_data;
      w_pend = i_byp_rsv_en && (i_byp_rsv_addr == i_rd_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_valid <= i_rd_en;
      if (i_rd_en) begin
        r_data <= w_data;
        r_pend <= w_pend;
      end
    end
  end

  assign o_rd_data  = r_data;
  assign o_rd_valid = r_valid;
  assign o_rd_pend  = r_pend;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file with N_RD registered read ports, one write port
// and a pending scoreboard. Define PARAM_REGFILE_BYPASS_EN for write-to-read bypass.
module param_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int N_RD     = RF_N_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_valid,
  output logic [N_RD-1:0]          rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DEPTH-1:0]         pend_vec,
  output logic                     rsv_err
);

`ifdef PARAM_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0]       r_regs [DEPTH];
  logic [DEPTH-1:0]        r_pend;
  logic                    r_rsv_err;

  logic                    w_wr_ok;
  logic                    w_rsv_ok;
  logic                    w_byp_wr_en;
  logic [DEPTH*DATA_W-1:0] w_regs_flat;

  // With a hardwired zero register, address 0 swallows writes and reserves.
  assign w_wr_ok     = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign w_rsv_ok    = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
  assign w_byp_wr_en = BYPASS && w_wr_ok;

  // Reserve is applied after the write so a same-address collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pend    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
        r_pend[wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_pend[rsv_addr] <= 1'b1;
        if (r_pend[rsv_addr]) begin
          r_rsv_err <= 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

    for (gi = 0; gi < N_RD; gi++) begin : g_port
      rf_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
      ) u_port (
        .clk            (clk),
        .reset          (reset),
        .i_rd_en        (rd_en[gi]),
        .i_rd_addr      (rd_addr[gi*ADDR_W +: ADDR_W]),
        .i_regs_flat    (w_regs_flat),
        .i_pend_vec     (r_pend),
        .i_byp_wr_en    (w_byp_wr_en),
        .i_byp_wr_addr  (wr_addr),
        .i_byp_wr_data  (wr_data),
        .i_byp_rsv_en   (w_rsv_ok),
        .i_byp_rsv_addr (rsv_addr),
        .o_rd_data      (rd_data[gi*DATA_W +: DATA_W]),
        .o_rd_valid     (rd_valid[gi]),
        .o_rd_pend      (rd_pend[gi])
      );
    end
  endgenerate

  assign pend_vec = r_pend;
  assign rsv_err  = r_rsv_err;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: two instances (ZERO_REG=0 and 1) share stimulus;
// an array-based model is compared every cycle, plus directed literal checks.
module tb_param_register_file;

`ifdef PARAM_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] rd_en;
  logic [3:0] rd_addr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsv_en;
  logic [1:0] rsv_addr;

  logic [1:0][15:0] o_rd_data;
  logic [1:0][1:0]  o_rd_valid;
  logic [1:0][1:0]  o_rd_pend;
  logic [1:0][3:0]  o_pend_vec;
  logic [1:0]       o_rsv_err;

  int n_tests = 0;
  int n_fail  = 0;

  param_register_file #(.DATA_W(8), .DEPTH(4), .N_RD(2), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]), .rd_pend(o_rd_pend[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(o_pend_vec[0]), .rsv_err(o_rsv_err[0])
  );

  param_register_file #(.DATA_W(8), .DEPTH(4), .N_RD(2), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]), .rd_pend(o_rd_pend[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(o_pend_vec[1]), .rsv_err(o_rsv_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, pending flags and sticky error per instance.
  logic [7:0] m_regs  [2][4];
  logic       m_pend  [2][4];
  logic       m_err   [2];
  logic [7:0] e_data  [2][2];
  logic       e_valid [2][2];
  logic       e_pend  [2][2];
  bit         model_live = 1'b0;

  function automatic bit is_zero_reg(input int d, input logic [1:0] a);
    return (d == 1) && (a == 2'd0);
  endfunction

  function automatic logic [7:0] model_data(input int d, input logic [1:0] a);
    if (is_zero_reg(d, a)) return 8'h00;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return m_regs[d][a];
  endfunction

  function automatic logic model_pend(input int d, input logic [1:0] a);
    if (is_zero_reg(d, a)) return 1'b0;
    if (BYP && wr_en && wr_addr == a) return rsv_en && rsv_addr == a;
    return m_pend[d][a];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int p = 0; p < 2; p++) begin
          e_valid[d][p] <= 1'b0;
          e_data[d][p]  <= 8'h00;
          e_pend[d][p]  <= 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
          m_regs[d][r] <= 8'h00;
          m_pend[d][r] <= 1'b0;
        end
        m_err[d] <= 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          e_valid[d][p] <= rd_en[p];
          if (rd_en[p]) begin
            e_data[d][p] <= model_data(d, rd_addr[p*2 +: 2]);
            e_pend[d][p] <= model_pend(d, rd_addr[p*2 +: 2]);
          end
        end
        if (wr_en && !is_zero_reg(d, wr_addr)) begin
          m_regs[d][wr_addr] <= wr_data;
          if (!(rsv_en && rsv_addr == wr_addr)) m_pend[d][wr_addr] <= 1'b0;
        end
        if (rsv_en && !is_zero_reg(d, rsv_addr)) begin
          m_pend[d][rsv_addr] <= 1'b1;
          if (m_pend[d][rsv_addr]) m_err[d] <= 1'b1;
        end
      end
    end
    if (reset) model_live <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          check($sformatf("model_valid d%0d p%0d", d, p), 32'(o_rd_valid[d][p]), 32'(e_valid[d][p]));
          check($sformatf("model_data d%0d p%0d", d, p), 32'(o_rd_data[d][p*8 +: 8]), 32'(e_data[d][p]));
          check($sformatf("model_pend d%0d p%0d", d, p), 32'(o_rd_pend[d][p]), 32'(e_pend[d][p]));
        end
        check($sformatf("model_pend_vec d%0d", d), 32'(o_pend_vec[d]),
              32'({m_pend[d][3], m_pend[d][2], m_pend[d][1], m_pend[d][0]}));
        check($sformatf("model_rsv_err d%0d", d), 32'(o_rsv_err[d]), 32'(m_err[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset  = 1'b0;
    rd_en  = 2'b00;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic rd(input int p, input logic [1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*2 +: 2] = a;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
  endtask

  task automatic rsv(input logic [1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    reset = 1'b1; rd_en = 2'b11; rd_addr = 4'h0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    rsv_en = 1'b0; rsv_addr = 2'd0;
    step(); step();
    $display("[TB] txn reset with reads pending");
    check("reset_valid", 32'(o_rd_valid[0]), 32'h0);
    check("reset_data", 32'(o_rd_data[0]), 32'h0);
    check("reset_pend_vec", 32'(o_pend_vec[0]), 32'h0);
    check("reset_rsv_err", 32'(o_rsv_err[0]), 32'h0);

    $display("[TB] txn write r2=A5, reset, read r2");
    idle(); wr(2'd2, 8'hA5); step();
    idle(); reset = 1'b1; step();
    idle(); rd(0, 2'd2); step();
    check("rst_read_data", 32'(o_rd_data[0][7:0]), 32'h00);
    check("rst_read_valid", 32'(o_rd_valid[0][0]), 32'h1);
    check("rst_read_pend", 32'(o_rd_pend[0][0]), 32'h0);

    $display("[TB] txn write r1=3C, dual-port read r1");
    idle(); wr(2'd1, 8'h3C); step();
    idle(); rd(0, 2'd1); rd(1, 2'd1); step();
    check("dual_read_data", 32'(o_rd_data[0]), 32'h3C3C);
    check("dual_read_valid", 32'(o_rd_valid[0]), 32'h3);
    idle(); step();
    check("idle_valid", 32'(o_rd_valid[0]), 32'h0);
    check("idle_hold_data", 32'(o_rd_data[0]), 32'h3C3C);

    $display("[TB] txn read-during-write r3");
    idle(); wr(2'd3, 8'h11); step();
    idle(); wr(2'd3, 8'h22); rd(0, 2'd3); step();
    check("rdw_data", 32'(o_rd_data[0][7:0]), BYP ? 32'h22 : 32'h11);
    idle(); rd(0, 2'd3); step();
    check("rdw_after", 32'(o_rd_data[0][7:0]), 32'h22);

    $display("[TB] txn scoreboard r1");
    idle(); rsv(2'd1); step();
    check("sb_pend_vec_set", 32'(o_pend_vec[0]), 32'h2);
    idle(); rd(1, 2'd1); step();
    check("sb_rd_pend", 32'(o_rd_pend[0][1]), 32'h1);
    check("sb_rd_data", 32'(o_rd_data[0][15:8]), 32'h3C);
    idle(); wr(2'd1, 8'h7E); step();
    check("sb_pend_vec_clr", 32'(o_pend_vec[0]), 32'h0);
    idle(); rd(1, 2'd1); step();
    check("sb_rd_after_wr", 32'(o_rd_data[0][15:8]), 32'h7E);
    check("sb_rd_pend_clr", 32'(o_rd_pend[0][1]), 32'h0);

    $display("[TB] txn reserve/write collision r2");
    idle(); rsv(2'd2); step();
    check("col_err_before", 32'(o_rsv_err[0]), 32'h0);
    idle(); rsv(2'd2); wr(2'd2, 8'h55); step();
    check("col_pend2", 32'(o_pend_vec[0][2]), 32'h1);
    check("col_err_set", 32'(o_rsv_err[0]), 32'h1);
    idle(); wr(2'd2, 8'h66); step();
    check("col_pend_clr", 32'(o_pend_vec[0]), 32'h0);
    check("col_err_sticky", 32'(o_rsv_err[0]), 32'h1);

    $display("[TB] txn zero register r0");
    idle(); reset = 1'b1; step();
    idle(); wr(2'd0, 8'hFF); rsv(2'd0); step();
    check("zr_pend_vec", 32'(o_pend_vec[1]), 32'h0);
    check("zr_rsv_err", 32'(o_rsv_err[1]), 32'h0);
    check("nz_pend_vec", 32'(o_pend_vec[0]), 32'h1);
    idle(); rd(0, 2'd0); rd(1, 2'd0); step();
    check("zr_rd_data", 32'(o_rd_data[1]), 32'h0000);
    check("zr_rd_pend", 32'(o_rd_pend[1]), 32'h0);
    check("nz_rd_data", 32'(o_rd_data[0]), 32'hFFFF);
    check("nz_rd_pend", 32'(o_rd_pend[0]), 32'h3);
    idle(); rsv(2'd0); step();
    check("nz_rsv_err", 32'(o_rsv_err[0]), 32'h1);
    check("zr_rsv_err_again", 32'(o_rsv_err[1]), 32'h0);

    $display("[TB] txn random traffic, 400 cycles");
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      rd_en    = 2'($urandom);
      rd_addr  = 4'($urandom);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom);
      wr_data  = 8'($urandom);
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = 2'($urandom);
      step();
    end
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
